// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADD_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Start/ready/done bundle between a datapath controller (master) and the serial adder (slave).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  // Handshake: an operation is accepted on a rising edge where start=1 and ready=1;
  // a/b/cin are captured on that edge only. done pulses for one cycle when sum/cout/ovf
  // are valid, and those results hold until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/full_adder.sv
// Combinational one-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, registered carry, operand and result shift registers.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  serial_adder_if.slave bus,
  output state_t fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             done_r;
  logic             cout_r;
  logic             ovf_r;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic             c_msb_in;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_one
      assign sum_next = fa_s;
    end else begin : g_sum_wide
      assign sum_next = {fa_s, sum_r[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // On the last bit the carry register holds the carry into the MSB.
  assign c_msb_in = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done_r <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            sum_r <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= fa_co;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            cout_r <= fa_co;
            ovf_r  <= c_msb_in ^ fa_co;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.cout  = cout_r;
  assign bus.ovf   = ovf_r;
  assign fsm_state = state;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder for WIDTH-bit operands.
- Processes one bit per clock through a single registered-carry full-adder cell. Trades latency for area compared with a ripple-carry array.
- Downstream consumer of the full-adder cell: it drives the cell's a/b/cin, consumes s/cout, stores s into a result shift register and feeds cout back as the next carry.
- Start/ready/done handshake with the datapath controller.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to begin an addition; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- ready  output  1  high in IDLE; block accepts start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; sum/cout/ovf valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, operand shift regs=0, carry=0, bit counter=0, sum=0, cout=0, ovf=0, done=0, busy=0, ready=1. Reset mid-RUN aborts the operation with no done pulse.
- All outputs are registered or decoded from registered state only. There are no combinational input-to-output paths.
- FSM states and transitions:
  - IDLE:
    - start=1: sh_a<=a, sh_b<=b, carry<=cin, cnt<=0, sum<=0, go to RUN.
    - start=0: stay in IDLE.
  - RUN: each edge, the full-adder cell takes sh_a[0], sh_b[0] and carry.
    - sum <= {s, sum[WIDTH-1:1]}.
    - carry <= cell cout.
    - Previous carry is kept in c_msb_in when cnt==WIDTH-1.
    - sh_a and sh_b shift right by one; cnt++.
    - When cnt==WIDTH-1, go to DONE. Final edge: cout<=cell cout, ovf<=c_in_msb XOR cell cout.
  - DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Decoded outputs: ready = (state==IDLE); busy = (state==RUN).
- Latency: start sampled at edge t0 gives done high in the cycle following edge t0+WIDTH. Next start is accepted at the earliest at edge t0+WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- start while in RUN or DONE is ignored. No queueing and no effect on the in-flight result.
- a/b/cin may change freely after the accepting edge.
- WIDTH=1: RUN lasts one cycle; ovf = cin XOR cout.
- Counter width is max(1, clog2(WIDTH)). There is no wrap-around, because the counter is cleared on accept.
- Arithmetic is unsigned modulo 2^WIDTH with carry out. ovf interprets the operands as two's complement.
- sum, cout and ovf retain their values through IDLE. They are cleared only by reset or on a new accept (sum only; cout/ovf update on the final bit).

Decomposition:
- Shared package (adder_pkg):
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default width constant ADD_WIDTH=8.
- Sub-module: instantiate the existing combinational full_adder cell for the per-bit sum/carry. All sequencing, carry register and shift registers live in serial_adder.

Test Plan:
- WIDTH=8, a=0x3C, b=0x25, cin=0, pulse start → done exactly 8 edges after accept; sum=0x61, cout=0, ovf=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- a=0x00, b=0x00, cin=1 → sum=0x01, cout=0. Then hold start=1 continuously → a new accept occurs each WIDTH+2 cycles, and start during RUN/DONE is ignored with operands unchanged.
- Change a/b to 0xAA/0x55 mid-RUN of 0x10+0x20 → result is still 0x30. Then assert rst_n=0 at bit 4 of a new op → all outputs zero immediately, no done, ready=1 after release.
- WIDTH=1 build: a=1, b=1, cin=1 → sum=1, cout=1, ovf=0, done one edge after accept.
- Randomised 1000 ops vs. reference model for WIDTH=8 and WIDTH=13: {cout,sum}==a+b+cin and ovf correct on every done.
